// File: rtl/regfile_mp_async_rstn_if.sv
// regfile_mp_async_rstn_if: read/write port bundle of the multi-port register file
// Signals: ren/raddr (read request), rdata/rvalid (registered read result),
// wen/waddr/wdata (write request), wr_conflict/addr_err (registered error pulses).
// Modports: master drives requests, slave is the register file.
interface regfile_mp_async_rstn_if #(
    parameter int WIDTH    = 32,
    parameter int N_REG    = 32,
    parameter int N_RPORTS = 2,
    parameter int N_WPORTS = 1
);
    localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1;
    logic [N_RPORTS-1:0]           ren;
    logic [N_RPORTS-1:0][AW-1:0]   raddr;
    logic [N_RPORTS-1:0][WIDTH-1:0] rdata;
    logic [N_RPORTS-1:0]           rvalid;
    logic [N_WPORTS-1:0]           wen;
    logic [N_WPORTS-1:0][AW-1:0]   waddr;
    logic [N_WPORTS-1:0][WIDTH-1:0] wdata;
    logic                          wr_conflict;
    logic                          addr_err;
    modport master (
        output ren, raddr, wen, waddr, wdata,
        input  rdata, rvalid, wr_conflict, addr_err
    );
    modport slave (
        input  ren, raddr, wen, waddr, wdata,
        output rdata, rvalid, wr_conflict, addr_err
    );
endinterface

// File: rtl/regfile_mp_async_rstn.sv
// regfile_mp_async_rstn: multi-port register file with registered reads and write priority
// Ports: clk (rising edge), rst_n (async active-low), bus (regfile_mp_async_rstn_if.slave):
//   ren/raddr -> rdata/rvalid one cycle later; wen/waddr/wdata write on the edge;
//   wr_conflict/addr_err are one-cycle registered error pulses.
// Optional feature macro: REGFILE_BYPASS_EN (write-first reads of same-cycle writes);
// undefined gives read-first with no bypass muxes.
module regfile_mp_async_rstn #(
    parameter int               WIDTH     = 32,
    parameter int               N_REG     = 32,
    parameter int               N_RPORTS  = 2,
    parameter int               N_WPORTS  = 1,
    parameter int               ZERO_REG  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_mp_async_rstn_if.slave bus
);
    localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1;
    logic [N_REG-1:0][WIDTH-1:0]    mem, mem_nxt;
    logic [N_RPORTS-1:0][WIDTH-1:0] rd;
    logic                           conflict, err;
    always_comb begin
        mem_nxt  = mem;
        rd       = '0;
        conflict = 1'b0;
        err      = 1'b0;
        // ascending port order lets the highest-index writer overwrite the others
        for (int r = 0; r < N_REG; r++)
            for (int k = 0; k < N_WPORTS; k++)
                if (bus.wen[k] && bus.waddr[k] == AW'(r) && !(ZERO_REG != 0 && r == 0))
                    mem_nxt[r] = bus.wdata[k];
        for (int k = 0; k < N_WPORTS; k++) begin
            err = err | (bus.wen[k] && int'(bus.waddr[k]) >= N_REG);
            for (int m = 0; m < k; m++)
                conflict = conflict | (bus.wen[k] && bus.wen[m] && bus.waddr[k] == bus.waddr[m]
                                       && int'(bus.waddr[k]) < N_REG);
        end
        // out-of-range and hardwired-zero reads fall through to the zero default
        for (int j = 0; j < N_RPORTS; j++) begin
            err = err | (bus.ren[j] && int'(bus.raddr[j]) >= N_REG);
            for (int r = 0; r < N_REG; r++)
                if (bus.raddr[j] == AW'(r) && !(ZERO_REG != 0 && r == 0))
`ifdef REGFILE_BYPASS_EN
                    rd[j] = mem_nxt[r];
`else
                    rd[j] = mem[r];
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem             <= {N_REG{RESET_VAL}};
            bus.rdata       <= '0;
            bus.rvalid      <= '0;
            bus.wr_conflict <= 1'b0;
            bus.addr_err    <= 1'b0;
        end else begin
            mem             <= mem_nxt;
            bus.rvalid      <= bus.ren;
            bus.wr_conflict <= conflict;
            bus.addr_err    <= err;
            for (int j = 0; j < N_RPORTS; j++)
                if (bus.ren[j]) bus.rdata[j] <= rd[j];
        end
    end
endmodule

// File: tb/tb_regfile_mp_async_rstn.sv
// tb_regfile_mp_async_rstn: directed plus random checks against an array-based model
module tb_regfile_mp_async_rstn;
    localparam int NR = 6;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    regfile_mp_async_rstn_if #(.WIDTH(8), .N_REG(NR), .N_RPORTS(2), .N_WPORTS(2)) bus ();
    regfile_mp_async_rstn #(
        .WIDTH(8), .N_REG(NR), .N_RPORTS(2), .N_WPORTS(2), .ZERO_REG(1), .RESET_VAL(8'hA5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );
    always #5 clk = ~clk;
    logic [7:0] mm [NR];
    logic [7:0] er [2];
    logic       ev [2];
    logic       e_conf, e_err;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all(input string tag);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("%s rdata%0d", tag, j), 32'(bus.rdata[j]), 32'(er[j]));
            check($sformatf("%s rvalid%0d", tag, j), 32'(bus.rvalid[j]), 32'(ev[j]));
        end
        check({tag, " wr_conflict"}, 32'(bus.wr_conflict), 32'(e_conf));
        check({tag, " addr_err"}, 32'(bus.addr_err), 32'(e_err));
    endtask
    function automatic void model_reset();
        for (int r = 0; r < NR; r++) mm[r] = 8'hA5;
        for (int j = 0; j < 2; j++) begin er[j] = 8'h00; ev[j] = 1'b0; end
        e_conf = 1'b0;
        e_err  = 1'b0;
    endfunction
    function automatic void model_step();
        logic [7:0] nm [NR];
        nm = mm;
        e_conf = 1'b0;
        e_err  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int a = int'(bus.waddr[k]);
            if (bus.wen[k]) begin
                if (a >= NR) e_err = 1'b1;
                else if (a != 0) nm[a] = bus.wdata[k];
            end
        end
        if (bus.wen == 2'b11 && bus.waddr[0] == bus.waddr[1] && int'(bus.waddr[0]) < NR) e_conf = 1'b1;
        for (int j = 0; j < 2; j++) begin
            int a = int'(bus.raddr[j]);
            ev[j] = bus.ren[j];
            if (bus.ren[j]) begin
                if (a >= NR) begin e_err = 1'b1; er[j] = 8'h00; end
                else if (a == 0) er[j] = 8'h00;
`ifdef REGFILE_BYPASS_EN
                else er[j] = nm[a];
`else
                else er[j] = mm[a];
`endif
            end
        end
        mm = nm;
    endfunction
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask
    task automatic drive(input logic [1:0] re, input int r0, input int r1, input logic [1:0] we,
                         input int a0, input int a1, input logic [7:0] d0, input logic [7:0] d1);
        bus.ren      = re;
        bus.raddr[0] = 3'(r0);
        bus.raddr[1] = 3'(r1);
        bus.wen      = we;
        bus.waddr[0] = 3'(a0);
        bus.waddr[1] = 3'(a1);
        bus.wdata[0] = d0;
        bus.wdata[1] = d1;
    endtask
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, " async"});
        @(posedge clk);
        #1;
        check_all({tag, " held"});
        rst_n = 1'b1;
    endtask
    initial begin
        drive(2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00);
        do_reset("rst0");
        drive(2'b01, 3, 0, 2'b00, 0, 0, 8'h00, 8'h00);
        tick("read_r3_reset_val");
        drive(2'b00, 0, 0, 2'b11, 5, 5, 8'h11, 8'h22);
        tick("priority");
        drive(2'b10, 0, 5, 2'b00, 0, 0, 8'h00, 8'h00);
        tick("priority_readback");
        check("r5_is_22", 32'(bus.rdata[1]), 32'h22);
        drive(2'b01, 4, 0, 2'b01, 4, 0, 8'h33, 8'h00);
        tick("bypass");
        drive(2'b01, 4, 0, 2'b00, 0, 0, 8'h00, 8'h00);
        tick("after_write_r4");
        check("r4_is_33", 32'(bus.rdata[0]), 32'h33);
        drive(2'b01, 0, 0, 2'b01, 0, 0, 8'hFF, 8'h00);
        tick("zero_reg_write");
        drive(2'b01, 0, 0, 2'b00, 0, 0, 8'h00, 8'h00);
        tick("zero_reg_read");
        drive(2'b01, 6, 0, 2'b01, 7, 0, 8'h77, 8'h00);
        tick("out_of_range");
        drive(2'b11, 1, 2, 2'b00, 0, 0, 8'h00, 8'h00);
        tick("oor_no_change");
        drive(2'b00, 0, 0, 2'b01, 2, 0, 8'h5A, 8'h00);
        tick("hold_setup_write");
        drive(2'b01, 2, 0, 2'b00, 0, 0, 8'h00, 8'h00);
        tick("hold_read");
        check("hold_read_5a", 32'(bus.rdata[0]), 32'h5A);
        drive(2'b00, 3, 3, 2'b00, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) tick($sformatf("hold%0d", i));
        drive(2'b11, 1, 2, 2'b00, 0, 0, 8'h00, 8'h00);
        do_reset("rst_mid");
        tick("after_mid_reset");
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom),
                  $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? int'(bus.waddr[0]) : $urandom_range(0, 7),
                  8'($urandom), 8'($urandom));
            if (bus.wen == 2'b11 && $urandom_range(0, 3) == 0) bus.waddr[1] = bus.waddr[0];
            tick($sformatf("rand%0d", i));
            if (i == 200) begin
                drive(2'b11, 2, 4, 2'b11, 1, 3, 8'h01, 8'h02);
                do_reset("rst_rand");
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
